// File: rtl/cevero_vf_sequencer.sv
// Applies DVFS voltage/frequency targets to the regulator and clock generator in a safe order:
// voltage rises before frequency rises, frequency falls before voltage falls, with settle and timeout.
module cevero_vf_sequencer #(
  parameter int VW             = 3,
  parameter int FW             = 32,
  parameter int DEF_VOLTAGE    = 5,
  parameter int DEF_FREQ       = 150,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [VW-1:0] target_voltage_i,
  input  logic [FW-1:0] target_freq_i,
  output logic [VW-1:0] vreg_code_o,
  output logic          vreg_req_o,
  input  logic          vreg_ack_i,
  output logic [FW-1:0] clk_freq_o,
  output logic          clk_req_o,
  input  logic          clk_ack_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          fault_o,
  output logic [2:0]    dbg_state_o
);

  // Handshake: a req is a level held from entry into its REQ state until the matching ack is
  // sampled high on a rising edge (an ack in the first req cycle counts); the req drops the
  // following cycle. Acks sampled while not in the matching REQ state are ignored.

  localparam int CMAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    VOLT_REQ    = 3'd1,
    VOLT_SETTLE = 3'd2,
    FREQ_REQ    = 3'd3,
    FAULT       = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] cur_v, tgt_v, vreg_code_q;
  logic [FW-1:0] cur_f, tgt_f, clk_freq_q;
  logic          up_q;
  logic          done_q;
  logic [CW-1:0] cnt_q;

  logic latch, cnt_clr, v_ack, f_ack, finish;
  logic mismatch, volt_then_freq, timeout_hit, settle_hit;

  assign mismatch       = (target_voltage_i != cur_v) || (target_freq_i != cur_f);
  assign volt_then_freq = up_q && (tgt_f != cur_f);
  assign timeout_hit    = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign settle_hit     = (cnt_q >= CW'(SETTLE_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    cnt_clr = 1'b0;
    v_ack   = 1'b0;
    f_ack   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mismatch) begin
          latch   = 1'b1;
          cnt_clr = 1'b1;
          if (target_voltage_i > cur_v)   state_d = VOLT_REQ;
          else if (target_freq_i != cur_f) state_d = FREQ_REQ;
          else                             state_d = VOLT_REQ;
        end
      end
      VOLT_REQ: begin
        if (vreg_ack_i) begin
          v_ack   = 1'b1;
          cnt_clr = 1'b1;
          if (SETTLE_CYCLES != 0) state_d = VOLT_SETTLE;
          else if (volt_then_freq) state_d = FREQ_REQ;
          else                     finish  = 1'b1;
        end else if (timeout_hit) begin
          state_d = FAULT;
        end
      end
      VOLT_SETTLE: begin
        if (settle_hit) begin
          cnt_clr = 1'b1;
          if (volt_then_freq) state_d = FREQ_REQ;
          else                finish  = 1'b1;
        end
      end
      FREQ_REQ: begin
        if (clk_ack_i) begin
          f_ack   = 1'b1;
          cnt_clr = 1'b1;
          if (!up_q && (tgt_v != cur_v)) state_d = VOLT_REQ;
          else                           finish  = 1'b1;
        end else if (timeout_hit) begin
          state_d = FAULT;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
    if (finish) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cur_v       <= VW'(DEF_VOLTAGE);
      cur_f       <= FW'(DEF_FREQ);
      tgt_v       <= VW'(DEF_VOLTAGE);
      tgt_f       <= FW'(DEF_FREQ);
      up_q        <= 1'b0;
      vreg_code_q <= VW'(DEF_VOLTAGE);
      clk_freq_q  <= FW'(DEF_FREQ);
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= finish;
      if (latch) begin
        tgt_v <= target_voltage_i;
        tgt_f <= target_freq_i;
        up_q  <= (target_voltage_i > cur_v);
      end
      if (v_ack) cur_v <= tgt_v;
      if (f_ack) cur_f <= tgt_f;
      // Outputs are loaded on REQ entry and then held, including through FAULT.
      if ((state_d == VOLT_REQ) && (state_q != VOLT_REQ))
        vreg_code_q <= latch ? target_voltage_i : tgt_v;
      if ((state_d == FREQ_REQ) && (state_q != FREQ_REQ))
        clk_freq_q <= latch ? target_freq_i : tgt_f;
      if (cnt_clr)                  cnt_q <= '0;
      else if (cnt_q != CW'(CMAX))  cnt_q <= cnt_q + CW'(1);
    end
  end

  assign vreg_code_o = vreg_code_q;
  assign clk_freq_o  = clk_freq_q;
  assign vreg_req_o  = (state_q == VOLT_REQ);
  assign clk_req_o   = (state_q == FREQ_REQ);
  assign busy_o      = (state_q != IDLE) && (state_q != FAULT);
  assign done_o      = done_q;
  assign fault_o     = (state_q == FAULT);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cevero_vf_sequencer.sv
// Bench for cevero_vf_sequencer: directed target changes, modelled regulator/clock acks,
// and an event scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_cevero_vf_sequencer;
  localparam int VW = 3;
  localparam int FW = 32;
  localparam int W  = 48;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [VW-1:0] tv;
  logic [FW-1:0] tf;
  logic [VW-1:0] vreg_code_o;
  logic          vreg_req_o;
  logic          vreg_ack_i = 1'b0;
  logic [FW-1:0] clk_freq_o;
  logic          clk_req_o;
  logic          clk_ack_i = 1'b0;
  logic          busy_o, done_o, fault_o;
  logic [2:0]    dbg_state_o;

  cevero_vf_sequencer dut (
    .clk_i(clk), .rst_i(rst_i),
    .target_voltage_i(tv), .target_freq_i(tf),
    .vreg_code_o(vreg_code_o), .vreg_req_o(vreg_req_o), .vreg_ack_i(vreg_ack_i),
    .clk_freq_o(clk_freq_o), .clk_req_o(clk_req_o), .clk_ack_i(clk_ack_i),
    .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];

  // responders: ack on the third negedge of a held req, plus manual forced pulses
  logic v_ack_en = 1'b1, c_ack_en = 1'b1, v_force = 1'b0, c_force = 1'b0;
  int   v_cnt = 0, c_cnt = 0;

  always @(negedge clk) begin
    if (rst_i || !vreg_req_o) v_cnt = 0; else v_cnt = v_cnt + 1;
    if (rst_i || !clk_req_o)  c_cnt = 0; else c_cnt = c_cnt + 1;
    vreg_ack_i = (v_ack_en && vreg_req_o && v_cnt >= 3) || v_force;
    clk_ack_i  = (c_ack_en && clk_req_o && c_cnt >= 3) || c_force;
  end

  // scoreboard helpers
  task automatic push(input logic [7:0] k, input logic [3:0] f, input logic [3:0] c,
                      input logic [31:0] q);
    exp_q.push_back({k, f, c, q});
  endtask

  function automatic logic [W-1:0] ev(input logic [7:0] k);
    return {k, fault_o, busy_o, vreg_req_o, clk_req_o, 4'(vreg_code_o), clk_freq_o};
  endfunction

  task automatic check_ev(input string n, input logic [W-1:0] got);
    logic [W-1:0] e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL %s: unexpected event got %h, expected none", n, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        mismatched++;
        $display("FAIL %s: got %h expected %h", n, got, e);
      end
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // monitor: events = req rising, settle gap length, done, fault rising
  logic pv = 1'b0, pc = 1'b0, pf = 1'b0, gap_act = 1'b0;
  int   gap = 0;

  always @(negedge clk) begin
    if (rst_i) begin
      pv = 1'b0; pc = 1'b0; pf = 1'b0; gap_act = 1'b0;
    end else begin
      compared++;
      if (vreg_req_o && clk_req_o) begin
        mismatched++;
        $display("FAIL req_overlap: got both reqs high, expected at most one");
      end
      if (pv && !vreg_req_o && !fault_o) begin
        gap_act = 1'b1; gap = 1;
      end else if (gap_act && !clk_req_o && !done_o) begin
        gap = gap + 1;
      end
      if (vreg_req_o && !pv) check_ev("vreg_req", ev(8'd1));
      if (clk_req_o && !pc) begin
        if (gap_act) begin
          check_ev("settle_gap", {8'd5, 4'd0, 4'd0, 32'(gap)});
          gap_act = 1'b0;
        end
        check_ev("clk_req", ev(8'd2));
      end
      if (done_o) begin
        if (gap_act) begin
          check_ev("settle_gap", {8'd5, 4'd0, 4'd0, 32'(gap)});
          gap_act = 1'b0;
        end
        check_ev("done", ev(8'd3));
      end
      if (fault_o && !pf) check_ev("fault", ev(8'd4));
      pv = vreg_req_o; pc = clk_req_o; pf = fault_o;
    end
  end

  // driver tasks
  task automatic wait_done(input string n);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_o) begin
        chk({n, "_busy_at_done"}, busy_o, 0);
        return;
      end
    end
    chk({n, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_vfall();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (vreg_req_o) seen = 1'b1;
      else if (seen) return;
    end
    chk("vreq_fall_timeout", 0, 1);
  endtask

  task automatic chk_defaults(input string n);
    chk({n, "_code"}, vreg_code_o, 5);
    chk({n, "_freq"}, clk_freq_o, 150);
    chk({n, "_vreq"}, vreg_req_o, 0);
    chk({n, "_creq"}, clk_req_o, 0);
    chk({n, "_busy"}, busy_o, 0);
  endtask

  initial begin
    bit got_fault;
    rst_i = 1'b1; tv = 3'd5; tf = 32'd150;
    // 1: reset state, no sequence afterwards
    repeat (3) @(negedge clk);
    chk_defaults("reset");
    chk("reset_done", done_o, 0);
    chk("reset_fault", fault_o, 0);
    rst_i = 1'b0;
    repeat (10) @(negedge clk);
    chk_defaults("idle_after_reset");

    // 2: raise 5/150 -> 6/200, voltage first then settle then frequency
    push(8'd1, 4'b0110, 4'd6, 32'd150);
    push(8'd5, 4'b0000, 4'd0, 32'd16);
    push(8'd2, 4'b0101, 4'd6, 32'd200);
    push(8'd3, 4'b0000, 4'd6, 32'd200);
    tv = 3'd6; tf = 32'd200;
    wait_done("seq_up");

    // 3: lower to 3/100, frequency first then voltage and settle
    @(negedge clk);
    push(8'd2, 4'b0101, 4'd6, 32'd100);
    push(8'd1, 4'b0110, 4'd3, 32'd100);
    push(8'd5, 4'b0000, 4'd0, 32'd16);
    push(8'd3, 4'b0000, 4'd3, 32'd100);
    tv = 3'd3; tf = 32'd100;
    wait_done("seq_down");

    // 4: targets move to 7/300 during settle of a 6/200 sequence
    @(negedge clk);
    push(8'd1, 4'b0110, 4'd6, 32'd100);
    push(8'd5, 4'b0000, 4'd0, 32'd16);
    push(8'd2, 4'b0101, 4'd6, 32'd200);
    push(8'd3, 4'b0000, 4'd6, 32'd200);
    push(8'd1, 4'b0110, 4'd7, 32'd200);
    push(8'd5, 4'b0000, 4'd0, 32'd16);
    push(8'd2, 4'b0101, 4'd7, 32'd300);
    push(8'd3, 4'b0000, 4'd7, 32'd300);
    tv = 3'd6; tf = 32'd200;
    wait_vfall();
    repeat (4) @(negedge clk);
    tv = 3'd7; tf = 32'd300;
    wait_done("seq_first");
    @(negedge clk);
    chk("restart_next_idle", vreg_req_o, 1);
    wait_done("seq_second");

    // 5: regulator never acks -> timeout fault, sticky
    @(negedge clk);
    v_ack_en = 1'b0;
    push(8'd1, 4'b0110, 4'd4, 32'd300);
    push(8'd4, 4'b1000, 4'd4, 32'd300);
    tv = 3'd4; tf = 32'd300;
    repeat (1000) @(negedge clk);
    chk("pre_timeout_vreq", vreg_req_o, 1);
    chk("pre_timeout_fault", fault_o, 0);
    got_fault = 1'b0;
    for (int i = 0; i < 100 && !got_fault; i++) begin
      @(negedge clk);
      got_fault = fault_o;
    end
    chk("fault_reached", got_fault, 1);
    v_force = 1'b1; tv = 3'd2; tf = 32'd50;
    repeat (2) @(negedge clk);
    v_force = 1'b0; c_force = 1'b1;
    repeat (2) @(negedge clk);
    c_force = 1'b0;
    repeat (20) @(negedge clk);
    chk("fault_sticky", fault_o, 1);
    chk("fault_vreq", vreg_req_o, 0);
    chk("fault_creq", clk_req_o, 0);
    chk("fault_busy", busy_o, 0);
    chk("fault_code_held", vreg_code_o, 4);
    chk("fault_freq_held", clk_freq_o, 300);

    // 6: reset during FREQ_REQ, then ack while idle is ignored
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    chk_defaults("fault_cleared");
    chk("fault_cleared_flag", fault_o, 0);
    tv = 3'd5; tf = 32'd150; v_ack_en = 1'b1; c_ack_en = 1'b0;
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    push(8'd2, 4'b0101, 4'd5, 32'd80);
    tf = 32'd80;
    repeat (5) @(negedge clk);
    chk("freq_req_held", clk_req_o, 1);
    chk("freq_req_word", clk_freq_o, 80);
    #2 rst_i = 1'b1;
    #1 chk_defaults("async_reset");
    tf = 32'd150;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    c_force = 1'b1;
    repeat (2) @(negedge clk);
    c_force = 1'b0;
    repeat (10) @(negedge clk);
    chk_defaults("idle_ack_ignored");
    chk("idle_no_done", done_o, 0);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
